// File: rtl/serial_adder_datapath.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_datapath
// Description : Bit-serial add datapath (LSB first) with operand, carry,
//               result and bit-count registers, driven by external strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             Mrst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             load,
    input  logic             enable,
    input  logic             rst_sum,
    input  logic             rst_reg,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             counterflag
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] c_CNT_MAX  = CW'(WIDTH);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;

    logic w_cnt_full;
    logic w_step;
    logic w_last_step;
    logic w_bit_sum;
    logic w_carry_next;

    assign w_cnt_full   = (r_cnt == c_CNT_MAX);
    // A step happens only when nothing higher-priority claims the edge and
    // the counter has not saturated.
    assign w_step       = enable & ~load & ~rst_reg & ~w_cnt_full;
    assign w_last_step  = w_step & (r_cnt == c_CNT_LAST);
    assign w_bit_sum    = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_carry_next = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

    always_ff @(posedge clk or negedge Mrst) begin
        if (!Mrst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (rst_reg) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (load) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_carry <= w_carry_next;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    // Result side is independent of rst_reg so a finished sum survives it.
    always_ff @(posedge clk or negedge Mrst) begin
        if (!Mrst) begin
            r_s    <= '0;
            r_cout <= 1'b0;
        end else if (rst_sum) begin
            r_s    <= '0;
            r_cout <= 1'b0;
        end else if (w_step) begin
            r_s <= {w_bit_sum, r_s[WIDTH-1:1]};
            if (w_last_step) begin
                r_cout <= w_carry_next;
            end
        end
    end

    assign sum         = r_s;
    assign cout        = r_cout;
    assign counterflag = w_cnt_full;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_datapath
// Description : Scoreboard bench; expected {cout,sum} queued at load, checked
//               by a monitor when counterflag rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_datapath;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             Mrst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             load;
    logic             enable;
    logic             rst_sum;
    logic             rst_reg;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             counterflag;

    int n_vec = 0;
    int n_err = 0;
    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] last_exp;
    logic           prev_flag = 1'b0;

    serial_adder_datapath #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .Mrst        (Mrst),
        .a           (a),
        .b           (b),
        .load        (load),
        .enable      (enable),
        .rst_sum     (rst_sum),
        .rst_reg     (rst_reg),
        .sum         (sum),
        .cout        (cout),
        .counterflag (counterflag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's strobes at the falling edge, return at the next one.
    task automatic cyc(input logic ld, input logic en, input logic rs, input logic rr);
        load = ld; enable = en; rst_sum = rs; rst_reg = rr;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0; enable = 1'b0; rst_sum = 1'b0; rst_reg = 1'b0;
    endtask

    task automatic run_add(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                           input logic rs, input logic en_on_load,
                           input int pause_at, input int pause_len, input bit gaps);
        int steps  = 0;
        int paused = 0;
        logic en;
        a = av; b = bv;
        cyc(1'b1, en_on_load, rs, 1'b0);
        last_exp = {1'b0, av} + {1'b0, bv};
        exp_q.push_back(last_exp);
        chk("flag_after_load", {31'd0, counterflag}, 32'd0);
        while (steps < WIDTH) begin
            en = 1'b1;
            if (steps == pause_at && paused < pause_len) begin
                en = 1'b0;
                paused++;
            end else if (gaps && ($urandom % 4 == 0)) begin
                en = 1'b0;
            end
            a = WIDTH'($urandom); b = WIDTH'($urandom);
            cyc(1'b0, en, 1'b0, 1'b0);
            if (en) steps++;
            chk("flag_step", {31'd0, counterflag}, (steps == WIDTH) ? 32'd1 : 32'd0);
        end
    endtask

    // Monitor: a rising counterflag presents a result.
    always @(negedge clk) begin
        if (counterflag && !prev_flag) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got %0h with empty scoreboard", {cout, sum});
            end else begin
                chk("result", {23'd0, cout, sum}, {23'd0, exp_q.pop_front()});
            end
        end
        prev_flag = counterflag;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        Mrst = 1'b0; a = '0; b = '0;
        load = 1'b0; enable = 1'b0; rst_sum = 1'b0; rst_reg = 1'b0;
        #12;
        chk("reset_sum",  {24'd0, sum}, 32'd0);
        chk("reset_cout", {31'd0, cout}, 32'd0);
        chk("reset_flag", {31'd0, counterflag}, 32'd0);
        @(negedge clk);
        Mrst = 1'b1;
        @(negedge clk);

        run_add(8'h5A, 8'h3C, 1'b1, 1'b0, -1, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            chk("sat_sum",  {24'd0, sum}, {24'd0, last_exp[WIDTH-1:0]});
            chk("sat_cout", {31'd0, cout}, {31'd0, last_exp[WIDTH]});
            chk("sat_flag", {31'd0, counterflag}, 32'd1);
        end

        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rstreg_flag", {31'd0, counterflag}, 32'd0);
        chk("rstreg_sum",  {24'd0, sum}, 32'h96);
        a = 8'h11; b = 8'h22;
        load = 1'b1; enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0; enable = 1'b0;
        chk("load_en_sum",  {24'd0, sum}, 32'h96);
        chk("load_en_flag", {31'd0, counterflag}, 32'd0);
        run_add(8'hFF, 8'h01, 1'b1, 1'b1, -1, 0, 1'b0);

        run_add(8'h81, 8'h81, 1'b1, 1'b0, 4, 3, 1'b0);

        // Asynchronous reset mid-add; this operation never produces a result.
        a = 8'hC3; b = 8'h77;
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        #2 Mrst = 1'b0;
        #1;
        chk("async_sum",  {24'd0, sum}, 32'd0);
        chk("async_cout", {31'd0, cout}, 32'd0);
        chk("async_flag", {31'd0, counterflag}, 32'd0);
        @(negedge clk);
        Mrst = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("async_noload_flag", {31'd0, counterflag}, 32'd0);
        run_add(8'h10, 8'h20, 1'b1, 1'b0, -1, 0, 1'b0);

        // Restart directly from a completed result.
        run_add(8'hAA, 8'h55, 1'b1, 1'b1, -1, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            run_add(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                    1'($urandom), -1, 0, 1'b1);
            if ($urandom % 3 == 0) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
